intermediate_stream_buffer: RTL and testbench
=============================================

# intermediate_stream_buffer

Parametrised inter-layer buffer between the ALU outputs of one neural-network layer and the serial input of the next. It captures a full layer vector of NUM_NEURONS words in one cycle into a DEPTH-entry queue. It streams the words out one per transfer under a valid/ready handshake, so a producer layer can run ahead of its consumer. It replaces single-vector capture-and-shift buffering with queued storage, backpressure, ordering control and flush.

## Interface
- NUM_NEURONS, 2, words per layer vector (≥1)
- BIT_WIDTH, 32, floating-point word size
- EXTRA_BITS, 0, Flopoco extra bits; only 0 or 2 legal; word width W = BIT_WIDTH+EXTRA_BITS
- DEPTH, 2, number of layer vectors stored (power of 2, ≥2)
- MSB_FIRST, 0, 0: word 0 = layer_output[W-1:0] leaves first; 1: top word leaves first

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- layer_output  in  NUM_NEURONS*W  parallel layer vector
- inter_en  in  1  capture request; producer holds until cap_ack
- cap_ack  out  1  one-cycle pulse: vector accepted
- full  out  1  occupancy == DEPTH
- occupancy  out  $clog2(DEPTH+1)  stored vectors, including the one being streamed
- flush  in  1  synchronous discard of all stored vectors
- shift_ready  in  1  consumer ready
- shift_valid  out  1  shift_res holds a valid word
- shift_res  out  W  current output word
- last_word  out  1  high with shift_valid on the final word of a vector

## Operation
- Storage: DEPTH slots of NUM_NEURONS*W bits, with write pointer wp, read pointer rp, word index widx (0..NUM_NEURONS-1) and occupancy counter cnt. Pointers wrap modulo DEPTH.
- Capture: when inter_en && !full at a clock edge, layer_output is written to slot wp, wp increments, and cap_ack is 1 in the next cycle.
- If full, inter_en is ignored and cap_ack stays 0.
- full is evaluated on registered state. A capture is refused when full, even if a pop happens in the same cycle.
- Continuous inter_en with room available captures one vector per cycle, and cap_ack pulses each cycle.
- Output: shift_valid = (cnt != 0). shift_res = word widx of slot rp, or word NUM_NEURONS-1-widx when MSB_FIRST=1. shift_res is 0 when cnt == 0.
- Transfer occurs when shift_valid && shift_ready.
  - If widx < NUM_NEURONS-1: widx increments.
  - Otherwise: widx returns to 0, rp increments, and the slot is freed.
- last_word = shift_valid && widx == NUM_NEURONS-1. For NUM_NEURONS=1, last_word equals shift_valid.
- Simultaneous capture and final-word transfer (not full): cnt is unchanged, both pointers advance.
- Capture only: cnt increments. Final-word transfer only: cnt decrements.
- shift_valid && !shift_ready holds shift_res, widx and last_word stable.
- flush: wp, rp, widx and cnt go to 0 next cycle. flush has priority over a same-cycle capture and transfer, and the capture is not acknowledged.
- Storage contents are not reset or cleared. Outputs mask them while empty.

## Timing
- Reset values, next cycle after rst=1: cap_ack 0, full 0, occupancy 0, shift_valid 0, shift_res 0, last_word 0. Internally wp=rp=widx=0.
- rst has priority over flush, inter_en and shift_ready.
- rst mid-stream abandons the partial vector. No cap_ack is issued for a capture in the reset cycle.
- Capture-to-output latency: 1 cycle. A vector captured at edge N into an empty buffer gives shift_valid=1 and word 0 valid after edge N.
- Throughput: 1 word/cycle with shift_ready held high. A vector needs NUM_NEURONS cycles.
- cap_ack, full, occupancy and shift_valid are registered or decoded from registers only. There is no combinational path from inter_en to cap_ack or from shift_ready to shift_valid.
- shift_res and last_word are decoded from registered state only. They do not depend combinationally on shift_ready.

## Test plan
- Reset, then capture 64'hEEEE_EEEE_AAAA_AAAA with shift_ready=1 and MSB_FIRST=0 -> cap_ack pulse 1 cycle after capture; then shift_res AAAAAAAA (last_word 0), then EEEEEEEE (last_word 1), then shift_valid 0.
- Same vector with MSB_FIRST=1 -> EEEEEEEE then AAAAAAAA.
- shift_ready=0, capture 64'hEEEE_EEEE_AAAA_AAAA, then 64'hFFFF_FFFF_BBBB_BBBB, then a third vector with inter_en held -> full=1 and occupancy=2; third vector gets no cap_ack. Release shift_ready -> AAAAAAAA, EEEEEEEE, BBBBBBBB, FFFFFFFF; third vector acked 1 cycle after the first slot frees.
- Backpressure: toggle shift_ready every cycle -> no word duplicated or dropped, and shift_res is stable while stalled.
- Full buffer, inter_en and final-word transfer in the same cycle -> capture refused, occupancy 2→1; capture succeeds the following cycle.
- Assert rst mid-vector (after word 0 sent), and separately flush with inter_en=1 -> next cycle shift_valid 0, occupancy 0, cap_ack 0; a fresh capture then streams from word 0.

Source files
------------

// File: rtl/intermediate_stream_buffer.sv
// Inter-layer buffer: captures whole layer vectors into a DEPTH-slot queue and
// streams them out one word per valid/ready transfer, with flush and backpressure.
module intermediate_stream_buffer #(
    parameter int NUM_NEURONS = 2,
    parameter int BIT_WIDTH   = 32,
    parameter int EXTRA_BITS  = 0,
    parameter int DEPTH       = 2,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_NEURONS*(BIT_WIDTH+EXTRA_BITS)-1:0]   layer_output,
    input  logic                                            inter_en,
    output logic                                            cap_ack,
    output logic                                            full,
    output logic [$clog2(DEPTH+1)-1:0]                      occupancy,
    input  logic                                            flush,
    input  logic                                            shift_ready,
    output logic                                            shift_valid,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]                 shift_res,
    output logic                                            last_word
);

    localparam int W  = BIT_WIDTH + EXTRA_BITS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [NUM_NEURONS*W-1:0] mem [DEPTH];
    logic [AW-1:0]            wp;
    logic [AW-1:0]            rp;
    logic [IW-1:0]            widx;
    logic [IW-1:0]            sel;
    logic [CW-1:0]            cnt;
    logic                     capture;
    logic                     xfer;
    logic                     final_xfer;

    assign full        = (cnt == FULL_CNT);
    assign occupancy   = cnt;
    assign shift_valid = (cnt != '0);
    assign last_word   = shift_valid && (widx == LAST_IDX);

    // full comes from registered cnt, so a same-cycle pop never makes room early
    assign capture    = inter_en && !full;
    assign xfer       = shift_valid && shift_ready;
    assign final_xfer = xfer && (widx == LAST_IDX);

    always_comb begin
        sel       = MSB_FIRST ? (LAST_IDX - widx) : widx;
        shift_res = '0;
        if (shift_valid) begin
            shift_res = mem[rp][int'(sel)*W +: W];
        end
    end

    // Storage is never cleared; empty slots are masked by cnt on the output side
    always_ff @(posedge clk) begin
        if (capture && !rst && !flush) begin
            mem[wp] <= layer_output;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp      <= '0;
            rp      <= '0;
            widx    <= '0;
            cnt     <= '0;
            cap_ack <= 1'b0;
        end else begin
            cap_ack <= capture;
            if (capture) begin
                wp <= wp + AW'(1);
            end
            if (xfer) begin
                if (widx == LAST_IDX) begin
                    widx <= '0;
                    rp   <= rp + AW'(1);
                end else begin
                    widx <= widx + IW'(1);
                end
            end
            case ({capture, final_xfer})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_intermediate_stream_buffer.sv
// Scoreboard bench for intermediate_stream_buffer: two instances (LSB-first and
// MSB-first) share stimulus; a word-level queue model predicts every output.
module tb_intermediate_stream_buffer;

    localparam int N     = 2;
    localparam int BW    = 32;
    localparam int EB    = 0;
    localparam int W     = BW + EB;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0] word;
        logic         last;
    } sb_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           inter_en;
    logic           shift_ready;
    logic [N*W-1:0] layer_output;

    logic           cap_ack     [2];
    logic           full        [2];
    logic [CW-1:0]  occupancy   [2];
    logic           shift_valid [2];
    logic [W-1:0]   shift_res   [2];
    logic           last_word   [2];

    sb_t sb_q0[$];
    sb_t sb_q1[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  nwords   = 0;
    bit  exp_ack  = 1'b0;
    bit  last_cap = 1'b0;
    bit  check_en = 1'b0;

    always #5 clk = ~clk;

    intermediate_stream_buffer #(
        .NUM_NEURONS(N), .BIT_WIDTH(BW), .EXTRA_BITS(EB), .DEPTH(DEPTH), .MSB_FIRST(1'b0)
    ) dut_lsb (
        .clk(clk), .rst(rst), .layer_output(layer_output), .inter_en(inter_en),
        .cap_ack(cap_ack[0]), .full(full[0]), .occupancy(occupancy[0]), .flush(flush),
        .shift_ready(shift_ready), .shift_valid(shift_valid[0]), .shift_res(shift_res[0]),
        .last_word(last_word[0])
    );

    intermediate_stream_buffer #(
        .NUM_NEURONS(N), .BIT_WIDTH(BW), .EXTRA_BITS(EB), .DEPTH(DEPTH), .MSB_FIRST(1'b1)
    ) dut_msb (
        .clk(clk), .rst(rst), .layer_output(layer_output), .inter_en(inter_en),
        .cap_ack(cap_ack[1]), .full(full[1]), .occupancy(occupancy[1]), .flush(flush),
        .shift_ready(shift_ready), .shift_valid(shift_valid[1]), .shift_res(shift_res[1]),
        .last_word(last_word[1])
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance the word-level model across the edge
    task automatic applyStimulus(input bit r, input bit f, input bit en, input bit rdy,
                                 input logic [N*W-1:0] data);
        int  occ_pre;
        bit  cap;
        rst          = r;
        flush        = f;
        inter_en     = en;
        shift_ready  = rdy;
        layer_output = data;
        @(posedge clk);
        cap = 1'b0;
        if (r || f) begin
            nwords = 0;
            sb_q0.delete();
            sb_q1.delete();
        end else begin
            occ_pre = (nwords + N - 1) / N;
            cap     = en && (occ_pre < DEPTH);
            if (nwords != 0 && rdy) nwords--;
            if (cap) begin
                nwords += N;
                for (int i = 0; i < N; i++) begin
                    sb_q0.push_back('{word: data[i*W +: W], last: (i == N - 1)});
                    sb_q1.push_back('{word: data[(N-1-i)*W +: W], last: (i == N - 1)});
                end
            end
        end
        exp_ack  = cap;
        last_cap = cap;
        #1;
    endtask

    task automatic produce(input logic [N*W-1:0] data, input bit rdy, input int max_cycles);
        bit acked = 1'b0;
        for (int i = 0; i < max_cycles && !acked; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, rdy, data);
            acked = last_cap;
        end
        if (!acked) checkOutput("capture_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    function automatic logic [N*W-1:0] randVec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic checkDut(input int d);
        sb_t e;
        bit  have;
        checkOutput($sformatf("cap_ack%0d", d), 64'(cap_ack[d]), 64'(exp_ack));
        checkOutput($sformatf("occupancy%0d", d), 64'(occupancy[d]), 64'((nwords + N - 1) / N));
        checkOutput($sformatf("full%0d", d), 64'(full[d]), 64'(((nwords + N - 1) / N) == DEPTH));
        checkOutput($sformatf("shift_valid%0d", d), 64'(shift_valid[d]), 64'(nwords != 0));
        if (!shift_valid[d]) begin
            checkOutput($sformatf("idle_res%0d", d), 64'(shift_res[d]), 64'd0);
            checkOutput($sformatf("idle_last%0d", d), 64'(last_word[d]), 64'd0);
        end else begin
            have = (d == 0) ? (sb_q0.size() != 0) : (sb_q1.size() != 0);
            if (!have) begin
                checkOutput($sformatf("valid_without_data%0d", d), 64'(shift_valid[d]), 64'd0);
            end else begin
                if (d == 0) e = sb_q0[0];
                else        e = sb_q1[0];
                checkOutput($sformatf("shift_res%0d", d), 64'(shift_res[d]), 64'(e.word));
                checkOutput($sformatf("last_word%0d", d), 64'(last_word[d]), 64'(e.last));
                if (shift_ready && !rst && !flush) begin
                    if (d == 0) void'(sb_q0.pop_front());
                    else        void'(sb_q1.pop_front());
                end
            end
        end
    endtask

    // Monitor: samples mid-cycle and consumes scoreboard entries on real transfers
    always @(negedge clk) begin
        if (check_en) begin
            checkDut(0);
            checkDut(1);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout at %0t", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [N*W-1:0] vec;
        bit             pending;
        bit             r;
        bit             f;
        bit             rdy;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        $display("[TB] single vector, streaming");
        produce(64'hEEEE_EEEE_AAAA_AAAA, 1'b1, 4);
        drain(4);

        $display("[TB] fill to full, refused third vector, release");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'hEEEE_EEEE_AAAA_AAAA);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_BBBB_BBBB);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h1111_1111_2222_2222);
        produce(64'h1111_1111_2222_2222, 1'b1, 10);
        drain(8);

        $display("[TB] reset mid-vector");
        produce(64'h3333_3333_4444_4444, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 64'h5555_5555_6666_6666);
        produce(64'h7777_7777_8888_8888, 1'b1, 4);
        drain(4);

        $display("[TB] flush with capture request");
        produce(64'h9999_9999_CCCC_CCCC, 1'b0, 4);
        produce(64'hDDDD_DDDD_1234_5678, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 64'hABCD_ABCD_0000_1111);
        produce(64'h0BAD_F00D_CAFE_BABE, 1'b1, 4);
        drain(4);

        $display("[TB] toggling backpressure, then random traffic");
        pending = 1'b0;
        vec     = '0;
        for (int i = 0; i < 1600; i++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                pending = 1'b1;
                vec     = randVec();
            end
            if (i < 200) begin
                rdy = ((i % 2) == 1);
                r   = 1'b0;
                f   = 1'b0;
            end else begin
                rdy = ($urandom_range(0, 2) != 0);
                r   = ($urandom_range(0, 149) == 0);
                f   = ($urandom_range(0, 59) == 0);
            end
            applyStimulus(r, f, pending, rdy, vec);
            if (last_cap) pending = 1'b0;
        end

        drain(2 * DEPTH * N + 2);
        checkOutput("scoreboard_drained_lsb", 64'(sb_q0.size()), 64'd0);
        checkOutput("scoreboard_drained_msb", 64'(sb_q1.size()), 64'd0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
